// File: rtl/sled_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package sled_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low segment codes {dp, g..a} for hex digits 0..F, dp off.
    localparam logic [7:0] SEG_CODES [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic {BLANK, ON} scan_state_t;

endpackage

// File: rtl/sled_hex_decode.sv
// Combinational hex-to-segment decoder with decimal point and digit blanking.
module sled_hex_decode
    import sled_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] code;

    assign code = SEG_CODES[nibble];
    // A blanked digit still shows its decimal point.
    assign seg  = blank ? {~dp, SEG_BLANK[6:0]} : {~dp, code[6:0]};

endmodule

// File: rtl/sled_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a blanking gap between digits
// and a double-buffered load port that commits only at frame boundaries.
module sled_scan_ctrl
    import sled_pkg::*;
#(
    parameter int DIV      = 50000,
    parameter int ON_TICKS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    input  logic        load,
    output logic        ready,
    output logic [7:0]  seg,
    output logic [3:0]  dig
);

    localparam int PW = $clog2(DIV);
    localparam int CW = (ON_TICKS > 1) ? $clog2(ON_TICKS) : 1;

    logic [PW-1:0] pre_cnt;
    logic          tick;
    scan_state_t   state;
    logic [1:0]    idx;
    logic [CW-1:0] on_cnt;
    logic          slot_end;
    logic          frame_end;

    logic [15:0] sh_value, disp_value;
    logic [3:0]  sh_dp, disp_dp;
    logic        sh_blz, disp_blz;
    logic        pending;

    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       cur_lz;
    logic [7:0] cur_seg;

    assign tick      = (pre_cnt == PW'(DIV - 1));
    assign slot_end  = tick && (state == ON) && (on_cnt == CW'(ON_TICKS - 1));
    assign frame_end = slot_end && (idx == 2'd3);

    // Load handshake: a transfer happens on any edge where load & ready; ready is
    // simply "shadow empty", so it stays low from the accepting edge until the
    // frame-end commit, and a commit can never race a new load.
    assign ready = ~pending;

    assign cur_nib = disp_value[{idx, 2'b00} +: 4];
    assign cur_dp  = disp_dp[idx];
    assign cur_lz  = disp_blz && (idx != 2'd0) && ((disp_value >> {idx, 2'b00}) == 16'd0);

    sled_hex_decode u_decode (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .blank  (cur_lz),
        .seg    (cur_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_value   <= '0;
            sh_dp      <= '0;
            sh_blz     <= 1'b0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_blz   <= 1'b0;
            pending    <= 1'b0;
        end else if (frame_end && pending) begin
            disp_value <= sh_value;
            disp_dp    <= sh_dp;
            disp_blz   <= sh_blz;
            pending    <= 1'b0;
        end else if (load && !pending) begin
            sh_value <= value;
            sh_dp    <= dp_in;
            sh_blz   <= blank_lz;
            pending  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BLANK;
            idx    <= 2'd0;
            on_cnt <= '0;
            seg    <= SEG_BLANK;
            dig    <= 4'hF;
        end else if (tick) begin
            case (state)
                BLANK: begin
                    state  <= ON;
                    on_cnt <= '0;
                    seg    <= cur_seg;
                    dig    <= ~(4'b0001 << idx);
                end
                ON: begin
                    if (slot_end) begin
                        state <= BLANK;
                        idx   <= idx + 2'd1;
                        seg   <= SEG_BLANK;
                        dig   <= 4'hF;
                    end else begin
                        on_cnt <= on_cnt + CW'(1);
                    end
                end
                default: state <= BLANK;
            endcase
        end
    end

endmodule

// File: tb/tb_sled_scan_ctrl.sv
// Randomized scoreboard bench for sled_scan_ctrl against a tick-arithmetic display model.
module tb_sled_scan_ctrl;

    localparam int DIV      = 4;
    localparam int ON_TICKS = 2;
    localparam int FRAME    = 4 * (ON_TICKS + 1) * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic        load = 1'b0;
    logic        ready;
    logic [7:0]  seg;
    logic [3:0]  dig;

    sled_scan_ctrl #(.DIV(DIV), .ON_TICKS(ON_TICKS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .load     (load),
        .ready    (ready),
        .seg      (seg),
        .dig      (dig)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] dig;
        logic [7:0] seg;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] codes [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc_n = 0;
    bit          m_pend = 1'b0;
    logic [15:0] m_val = '0, s_val = '0;
    logic [3:0]  m_dp = '0, s_dp = '0;
    logic        m_blz = 1'b0, s_blz = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int k);
        logic [3:0] nib;
        logic       dp;
        logic       bl;
        logic [7:0] code;
        nib  = 4'((m_val >> (4 * k)) & 16'hF);
        dp   = m_dp[k];
        bl   = m_blz && (k > 0) && ((m_val >> (4 * k)) == 16'd0);
        code = codes[nib];
        return bl ? {~dp, 7'h7F} : {~dp, code[6:0]};
    endfunction

    // Reference model: display timeline derived from the tick number since reset release.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            cyc_n  = 0;
            m_pend = 1'b0;
            m_val  = '0;
            m_dp   = '0;
            m_blz  = 1'b0;
            exp_q.delete();
        end else begin
            int   tk, ph, d;
            exp_t e;
            cyc_n++;
            if (load && !m_pend) begin
                s_val  = value;
                s_dp   = dp_in;
                s_blz  = blank_lz;
                m_pend = 1'b1;
            end
            if (cyc_n % DIV == 0) begin
                tk = cyc_n / DIV;
                ph = (tk - 1) % (ON_TICKS + 1);
                d  = ((tk - 1) / (ON_TICKS + 1)) % 4;
                e.cyc = cyc_n;
                if (ph == 0) begin
                    e.dig = 4'hF;
                    e.dig[d] = 1'b0;
                    e.seg = exp_seg(d);
                    exp_q.push_back(e);
                end else if (ph == ON_TICKS) begin
                    e.dig = 4'hF;
                    e.seg = 8'hFF;
                    exp_q.push_back(e);
                    if (d == 3 && m_pend) begin
                        m_val  = s_val;
                        m_dp   = s_dp;
                        m_blz  = s_blz;
                        m_pend = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: compares every change of the seg/dig pins against the expected queue.
    logic [11:0] last_out = 12'hFFF;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            last_out = 12'hFFF;
        end else begin
            check("ready", {31'd0, ready}, {31'd0, !m_pend});
            if ({dig, seg} != last_out) begin
                last_out = {dig, seg};
                if (exp_q.size() == 0) begin
                    check("unexpected_change", {20'd0, dig, seg}, {20'd0, 12'hFFF});
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_cycle", cyc_n, e.cyc);
                    check("dig", {28'd0, dig}, {28'd0, e.dig});
                    check("seg", {24'd0, seg}, {24'd0, e.seg});
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc_n) begin
                exp_t e;
                e = exp_q.pop_front();
                check("missing_change", {20'd0, dig, seg}, {20'd0, e.dig, e.seg});
            end
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
        int t;
        t = 0;
        while (!ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!ready) check("ready_timeout", 32'd0, 32'd1);
        value    = v;
        dp_in    = d;
        blank_lz = b;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        logic [15:0] rv;
        int          t;

        repeat (3) @(negedge clk);
        check("rst_seg", {24'd0, seg}, 32'hFF);
        check("rst_dig", {28'd0, dig}, 32'hF);
        check("rst_ready", {31'd0, ready}, 32'd1);
        rst_n = 1'b1;
        repeat (FRAME + 4) @(negedge clk);

        do_load(16'h1234, 4'b0000, 1'b0);
        repeat (2 * FRAME) @(negedge clk);
        do_load(16'h0070, 4'b0000, 1'b1);
        repeat (2 * FRAME) @(negedge clk);
        do_load(16'h0000, 4'b0000, 1'b1);
        repeat (2 * FRAME) @(negedge clk);
        do_load(16'h8888, 4'b0100, 1'b0);
        repeat (2 * FRAME) @(negedge clk);

        // Second load while the shadow is full must be ignored.
        do_load(16'hABCD, 4'b1001, 1'b0);
        value = 16'hFFFF;
        dp_in = 4'hF;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        repeat (400) begin
            rv       = 16'($urandom);
            rv       = rv >> (4 * $urandom_range(0, 3));
            value    = rv;
            dp_in    = 4'($urandom);
            blank_lz = 1'($urandom);
            load     = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        load = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        // Reset between edges during a lit slot, with a load still pending.
        do_load(16'h5A5A, 4'b1111, 1'b0);
        t = 0;
        while (dig == 4'hF && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("lit_slot_found", {31'd0, (dig != 4'hF)}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_seg", {24'd0, seg}, 32'hFF);
        check("async_rst_dig", {28'd0, dig}, 32'hF);
        check("async_rst_ready", {31'd0, ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME + 8) @(negedge clk);

        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sled_scan_ctrl.md
# sled_scan_ctrl

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display. Takes a 16-bit hex value, per-digit decimal points and a leading-zero-blank flag through a valid/ready load port. It sequences one digit at a time onto the shared `seg` bus, with a blanking gap between digits to suppress ghosting. New values are double-buffered and committed only at frame boundaries, so a frame never tears. It sits between the counter/data logic and the board's `seg`/`dig` pins.

## Interface
- `DIV`, 50000: clock cycles per scan tick (1 kHz at 50 MHz); must be ≥2.
- `ON_TICKS`, 3: ticks each digit stays lit; must be ≥1.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `value`  in  16  hex digits; [3:0] is digit 0 (rightmost) … [15:12] is digit 3.
- `dp_in`  in  4  decimal point per digit; 1 = lit.
- `blank_lz`  in  1  1 = blank leading zeros on digits 3..1.
- `load`  in  1  valid; sampled with `value`/`dp_in`/`blank_lz`.
- `ready`  out  1  shadow buffer free; a load is accepted when `load & ready`.
- `seg`  out  8  active-low segments, bit 7 = dp, bits 6:0 = g..a.
- `dig`  out  4  active-low digit enables, one-hot-low or all-high.

## Operation
- Segment codes, before dp: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E. Output `seg = {~dp, code[6:0]}`. Blank = 8'hFF.
- Prescaler counts 0..DIV-1. `tick` is a 1-cycle pulse when the count is DIV-1; the count then wraps to 0.
- FSM states BLANK and ON, digit index `idx` 0..3, tick counter `on_cnt`.
  - BLANK, on tick → ON. `dig` = low on bit `idx`, `seg` = decoded digit `idx`, `on_cnt` = 0.
  - ON, on tick: if `on_cnt == ON_TICKS-1` → BLANK, `dig`=F, `seg`=FF, `idx` = `idx`+1 mod 4. Otherwise `on_cnt`+1.
  - Leaving ON with `idx==3` is the frame end. If the shadow buffer is pending, display ← shadow and pending is cleared in the same cycle.
- Load port: `load & ready` captures value/dp/blank_lz into the shadow buffer and sets pending. `ready = ~pending`. `load` while `ready`=0 is ignored.
  - A load cannot coincide with a commit, because `ready` is 0 whenever a commit is possible.
- Leading-zero blank (uses the display copy of `blank_lz`): digit k∈{3,2,1} is blanked when its nibble and all higher nibbles are 0. Its dp still shows if set (`seg = {~dp, 7'h7F}`). Digit 0 is never blanked.
- Display buffer holds 16'h0000, dp 0, blank_lz 0 after reset.

## Timing
- Reset values:
  - `seg`=8'hFF, `dig`=4'hF, `ready`=1.
  - FSM=BLANK, `idx`=0, prescaler=0, pending=0, display and shadow zeroed.
- `seg`/`dig` are registered and change on the edge where `tick` is high.
- First digit is lit DIV cycles after reset release. Thereafter each digit is lit ON_TICKS·DIV cycles, then blank for DIV cycles.
- Frame = 4·(ON_TICKS+1)·DIV cycles.
- `ready` falls the cycle after an accepted load. It rises the cycle after the commit edge.
- Load-to-display latency is at most one frame plus one digit slot. A committed value is first shown on digit 0 of the next frame.
- Reset asserted mid-operation forces all outputs to their reset values immediately, without a clock. Any pending load is discarded.

## Structure
- Package `sled_pkg`: the `SEG_BLANK` (8'hFF) constant, the 16-entry segment-code constant array, and the FSM state enum {BLANK, ON}.
- Sub-module `sled_hex_decode` (combinational): inputs nibble, dp, blank; output 8-bit `seg` code. It is instantiated once on the `idx`-selected digit.
- Prescaler, FSM, load buffer and blanking logic live in `sled_scan_ctrl`.

## Test plan
Sim parameters: DIV=4, ON_TICKS=2.
- Reset: hold `rst_n`=0 → `seg`=FF, `dig`=F, `ready`=1. Release → first `dig`=1110 exactly 4 cycles later with `seg`=C0, lit 8 cycles, then 4 cycles of F/FF.
- Load 16'h1234, dp=0, blank_lz=0 → from the next frame: dig 1110/99, 1101/B0, 1011/A4, 0111/F9 in order, each separated by blank.
- blank_lz=1, value 16'h0070 → digits 3 and 2 FF, digit 1 F8, digit 0 C0. Value 16'h0000 → only digit 0 lit, with C0.
- value 16'h8888, dp_in=4'b0100 → digit 2 `seg`=00, others 80.
- Load mid-frame → `ready`=0 next cycle. A second load with 16'hFFFF while `ready`=0 is ignored. The display changes only at the frame end, and `ready` returns to 1 one cycle after the commit.
- Assert `rst_n` during an ON slot between clock edges → `seg`/`dig` go to FF/F immediately and `ready`=1. After release the display shows 0000.
